// File: rtl/host_link_controller_pkg.sv
// host_link_controller_pkg: phase encoding and default sizes shared by the link controller files
package host_link_controller_pkg;
  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, UNLOAD = 2'd2, DONE = 2'd3} phase_t;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_OUT_BASE  = 0;
  localparam int DEF_OUT_LEN   = 16;
endpackage

// File: rtl/host_link_controller_if.sv
// host_link_controller_if: host pins, core handshake and shared data-memory port of the link controller
interface host_link_controller_if
  import host_link_controller_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [DATA_W-1:0] com_data_in, com_data_out, mem_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0] state;
  logic data_write_start, data_write_done, cores_done, mem_we, cores_start;
  logic output_write_start, output_write_done, load_overflow;
  modport slave (
    input  com_data_in, data_write_start, data_write_done, cores_done, mem_rdata,
    output state, mem_addr, mem_wdata, mem_we, cores_start, com_data_out,
    output output_write_start, output_write_done, load_overflow
  );
  modport master (
    output com_data_in, data_write_start, data_write_done, cores_done, mem_rdata,
    input  state, mem_addr, mem_wdata, mem_we, cores_start, com_data_out,
    input  output_write_start, output_write_done, load_overflow
  );
endinterface

// File: rtl/host_link_controller_unload_seq.sv
// host_link_controller_unload_seq: issues OUT_LEN read addresses and aligns the 1-cycle memory latency into valid/last
module host_link_controller_unload_seq
  import host_link_controller_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int OUT_BASE = DEF_OUT_BASE,
  parameter int OUT_LEN  = DEF_OUT_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last
);
  logic active, rvalid, rlast;
  logic [ADDR_W:0] left;
  // data/valid/last are never cleared after the final word so the DONE phase keeps presenting it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      left    <= '0;
      rd_addr <= '0;
      data    <= '0;
      valid   <= 1'b0;
      last    <= 1'b0;
    end else begin
      if (start) begin
        active  <= 1'b1;
        rd_addr <= ADDR_W'(OUT_BASE);
        left    <= (ADDR_W+1)'(OUT_LEN - 1);
      end else if (active && left != '0) begin
        rd_addr <= rd_addr + 1'b1;
        left    <= left - 1'b1;
      end else begin
        active <= 1'b0;
      end
      rvalid <= active;
      rlast  <= active && left == '0;
      if (rvalid) begin
        data  <= mem_rdata;
        valid <= 1'b1;
        last  <= rlast;
      end
    end
  end
endmodule

// File: rtl/host_link_controller.sv
// host_link_controller: loads the host word stream into data memory, starts the cores, then streams the result window back
module host_link_controller
  import host_link_controller_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int OUT_BASE  = DEF_OUT_BASE,
  parameter int OUT_LEN   = DEF_OUT_LEN
) (
  input logic                  clk,
  input logic                  rst_n,
  host_link_controller_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  phase_t phase, phase_nx;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wdata, rdata_out;
  logic we, cs, ovf, start, valid, last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= LOAD;
    else phase <= phase_nx;
  end
  always_comb begin
    phase_nx = phase == LOAD   ? (bus.data_write_done ? RUN : LOAD) :
               phase == RUN    ? (bus.cores_done ? UNLOAD : RUN) :
               phase == UNLOAD ? (last ? DONE : UNLOAD) : DONE;
  end
  always_comb begin
    start                  = phase == RUN && bus.cores_done;
    bus.state              = phase;
    bus.mem_addr           = (phase == UNLOAD || phase == DONE) ? rd_addr : wr_addr;
    bus.mem_wdata          = wdata;
    bus.mem_we             = we;
    bus.cores_start        = cs;
    bus.load_overflow      = ovf;
    bus.com_data_out       = rdata_out;
    bus.output_write_start = valid;
    bus.output_write_done  = last;
  end
  // wr_ptr is one bit wider than the address so it can sit at MEM_DEPTH once memory is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wr_addr <= '0;
      wdata   <= '0;
      we      <= 1'b0;
      ovf     <= 1'b0;
      cs      <= 1'b0;
    end else begin
      we <= 1'b0;
      cs <= phase == LOAD && bus.data_write_done;
      if (phase == LOAD && bus.data_write_start) begin
        if (wr_ptr == DEPTH) begin
          ovf <= 1'b1;
        end else begin
          we      <= 1'b1;
          wr_addr <= wr_ptr[ADDR_W-1:0];
          wdata   <= bus.com_data_in;
          wr_ptr  <= wr_ptr + 1'b1;
        end
      end
    end
  end
  host_link_controller_unload_seq #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_BASE(OUT_BASE), .OUT_LEN(OUT_LEN)
  ) u_unload (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_rdata(bus.mem_rdata),
    .rd_addr(rd_addr), .data(rdata_out), .valid(valid), .last(last)
  );
endmodule

// File: tb/tb_host_link_controller.sv
// tb_host_link_controller: directed load/run/unload, reset and overflow checks against a synchronous memory model
module tb_host_link_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_cmp = 0, n_fail = 0;
  logic [15:0] mema [256] = '{default: 16'd0};
  logic [15:0] memb [256] = '{default: 16'd0};
  host_link_controller_if #(.DATA_W(16), .ADDR_W(8)) ia ();
  host_link_controller_if #(.DATA_W(16), .ADDR_W(8)) ib ();
  host_link_controller #(.OUT_LEN(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  host_link_controller #(.MEM_DEPTH(4), .OUT_LEN(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ia.mem_we) mema[ia.mem_addr] <= ia.mem_wdata;
    ia.mem_rdata <= mema[ia.mem_addr];
    if (ib.mem_we) memb[ib.mem_addr] <= ib.mem_wdata;
    ib.mem_rdata <= memb[ib.mem_addr];
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_state"}, 32'(ia.state), 0);
    chk({tag, "_we"}, 32'(ia.mem_we), 0);
    chk({tag, "_addr"}, 32'(ia.mem_addr), 0);
    chk({tag, "_wdata"}, 32'(ia.mem_wdata), 0);
    chk({tag, "_cs"}, 32'(ia.cores_start), 0);
    chk({tag, "_cdo"}, 32'(ia.com_data_out), 0);
    chk({tag, "_ows"}, 32'(ia.output_write_start), 0);
    chk({tag, "_owd"}, 32'(ia.output_write_done), 0);
    chk({tag, "_ovf"}, 32'(ia.load_overflow), 0);
  endtask
  initial begin
    {ia.com_data_in, ia.data_write_start, ia.data_write_done, ia.cores_done} = '0;
    {ib.com_data_in, ib.data_write_start, ib.data_write_done, ib.cores_done} = '0;
    step();
    step();
    rst_chk("rst");
    rst_n = 1'b1;
    step();
    ia.cores_done = 1'b1;
    step();
    chk("ign_cd_state", 32'(ia.state), 0);
    chk("ign_cd_cs", 32'(ia.cores_start), 0);
    ia.cores_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ia.data_write_start = 1'b1;
      ia.com_data_in = 16'(10 * (i + 1));
      step();
      chk("ld_we", 32'(ia.mem_we), 1);
      chk("ld_addr", 32'(ia.mem_addr), 32'(i));
      chk("ld_wdata", 32'(ia.mem_wdata), 32'(10 * (i + 1)));
    end
    ia.data_write_start = 1'b0;
    ia.data_write_done = 1'b1;
    step();
    ia.data_write_done = 1'b0;
    chk("run_state", 32'(ia.state), 1);
    chk("cs_high", 32'(ia.cores_start), 1);
    chk("run_we", 32'(ia.mem_we), 0);
    step();
    chk("cs_low", 32'(ia.cores_start), 0);
    for (int i = 0; i < 5; i++) chk("mem_load", 32'(mema[i]), 32'(10 * (i + 1)));
    step();
    ia.cores_done = 1'b1;
    step();
    ia.cores_done = 1'b0;
    chk("unl_state", 32'(ia.state), 2);
    chk("unl_e0_ows", 32'(ia.output_write_start), 0);
    step();
    chk("unl_e1_ows", 32'(ia.output_write_start), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("unl_ows", 32'(ia.output_write_start), 1);
      chk("unl_cdo", 32'(ia.com_data_out), 32'(10 * (i + 1)));
      chk("unl_owd", 32'(ia.output_write_done), 32'(i == 3));
    end
    step();
    chk("done_state", 32'(ia.state), 3);
    chk("done_cdo", 32'(ia.com_data_out), 40);
    chk("done_ows", 32'(ia.output_write_start), 1);
    chk("done_owd", 32'(ia.output_write_done), 1);
    {ia.data_write_start, ia.data_write_done, ia.cores_done} = 3'b111;
    ia.com_data_in = 16'd99;
    step();
    step();
    {ia.data_write_start, ia.data_write_done, ia.cores_done} = 3'b000;
    chk("done_hold_state", 32'(ia.state), 3);
    chk("done_hold_cdo", 32'(ia.com_data_out), 40);
    chk("done_hold_we", 32'(ia.mem_we), 0);
    chk("done_hold_cs", 32'(ia.cores_start), 0);
    rst_n = 1'b0;
    #2;
    rst_chk("rst_done");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ia.data_write_start = 1'b1;
      ia.com_data_in = 16'(5 + i);
      step();
    end
    ia.data_write_done = 1'b1;
    ia.com_data_in = 16'd77;
    step();
    {ia.data_write_start, ia.data_write_done} = 2'b00;
    chk("same_we", 32'(ia.mem_we), 1);
    chk("same_addr", 32'(ia.mem_addr), 3);
    chk("same_wdata", 32'(ia.mem_wdata), 77);
    chk("same_state", 32'(ia.state), 1);
    chk("same_cs", 32'(ia.cores_start), 1);
    ia.cores_done = 1'b1;
    step();
    ia.cores_done = 1'b0;
    chk("cd_in_cs_state", 32'(ia.state), 2);
    chk("mem_77", 32'(mema[3]), 77);
    step();
    step();
    chk("mid_w0", 32'(ia.com_data_out), 5);
    step();
    chk("mid_w1", 32'(ia.com_data_out), 6);
    rst_n = 1'b0;
    #2;
    rst_chk("rst_mid");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ia.data_write_start = 1'b1;
      ia.com_data_in = 16'(100 + i);
      step();
    end
    ia.data_write_start = 1'b0;
    ia.data_write_done = 1'b1;
    step();
    ia.data_write_done = 1'b0;
    ia.cores_done = 1'b1;
    step();
    ia.cores_done = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fresh_ows", 32'(ia.output_write_start), 1);
      chk("fresh_cdo", 32'(ia.com_data_out), 32'(100 + i));
      chk("fresh_owd", 32'(ia.output_write_done), 32'(i == 3));
    end
    step();
    chk("fresh_state", 32'(ia.state), 3);
    for (int i = 0; i < 6; i++) begin
      ib.data_write_start = 1'b1;
      ib.com_data_in = 16'(i + 1);
      step();
      chk("ovf_we", 32'(ib.mem_we), 32'(i < 4));
      chk("ovf_flag", 32'(ib.load_overflow), 32'(i >= 4));
    end
    ib.data_write_start = 1'b0;
    ib.data_write_done = 1'b1;
    step();
    ib.data_write_done = 1'b0;
    chk("ovf_state", 32'(ib.state), 1);
    step();
    chk("ovf_sticky", 32'(ib.load_overflow), 1);
    for (int i = 0; i < 4; i++) chk("ovf_mem", 32'(memb[i]), 32'(i + 1));
    chk("ovf_mem4", 32'(memb[4]), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
